// File: rtl/bram_lane_accumulator_pkg.sv
// bram_lane_accumulator_pkg: shared FSM encoding, mode constants and lane-slice helper
package bram_lane_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic MODE_RUNNING = 1'b0;
  localparam logic MODE_FINAL   = 1'b1;

  function automatic int lane_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/bram_lane_accumulator_lane.sv
// bram_acc_lane: single-lane accumulator with clear, valid, sum and carry/clamp flag.
// BRAM_ACC_SAT_EN selects saturation at the maximum value instead of modulo wrap.
module bram_acc_lane #(
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic                 vld_i,
  input  logic [IN_WIDTH-1:0]  in_i,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic                 ovf_o
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + (ACC_WIDTH+1)'(in_i);
    ovf_o = vld_i && sum[ACC_WIDTH];
`ifdef BRAM_ACC_SAT_EN
    acc_d = clr_i ? '0 : vld_i ? (sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0]) : acc_q;
`else
    acc_d = clr_i ? '0 : vld_i ? sum[ACC_WIDTH-1:0] : acc_q;
`endif
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;

  assign sum_o = acc_q;

endmodule

// File: rtl/bram_lane_accumulator.sv
// bram_lane_accumulator: streams BRAM0 rows, accumulates N_LANES lanes, writes sums to BRAM1.
// Optional BRAM_ACC_SAT_EN makes every lane saturate instead of wrapping.
module bram_lane_accumulator
  import bram_lane_accumulator_pkg::*;
#(
  parameter int N_LANES    = 4,
  parameter int IN_WIDTH   = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int AWIDTH     = 8,
  parameter int MEM_SIZE   = 256,
  parameter int RD_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_i,
  input  logic [AWIDTH:0]                run_count_i,
  input  logic                           mode_i,
  input  logic [N_LANES*IN_WIDTH-1:0]    q_b0_i,
  output logic [AWIDTH-1:0]              addr_b0_o,
  output logic                           ce_b0_o,
  output logic                           we_b0_o,
  output logic [N_LANES*IN_WIDTH-1:0]    d_b0_o,
  output logic [AWIDTH-1:0]              addr_b1_o,
  output logic                           ce_b1_o,
  output logic                           we_b1_o,
  output logic [N_LANES*ACC_WIDTH-1:0]   d_b1_o,
  output logic                           idle_o,
  output logic                           read_o,
  output logic                           write_o,
  output logic                           done_o,
  output logic                           overflow_o
);

  localparam int CW = AWIDTH + 1;

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d, rd_cnt_q, rd_cnt_d, acc_cnt_q, acc_cnt_d;
  logic                  mode_q, mode_d, wr_q, wr_d, ovf_q, ovf_d;
  logic [AWIDTH-1:0]     wr_addr_q, wr_addr_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic                  accept, vld;
  logic [N_LANES-1:0]    lane_ovf;

  always_comb begin
    accept    = state_q == ST_IDLE && start_i;
    vld       = vld_q[RD_LATENCY-1];
    count_d   = accept ? (run_count_i > CW'(MEM_SIZE) ? CW'(MEM_SIZE) : run_count_i) : count_q;
    mode_d    = accept ? mode_i : mode_q;
    rd_cnt_d  = accept ? '0 : state_q == ST_RUN ? rd_cnt_q + CW'(1) : rd_cnt_q;
    acc_cnt_d = accept ? '0 : vld ? acc_cnt_q + CW'(1) : acc_cnt_q;
    // in final mode only the last accumulated row produces a write
    wr_d      = vld && (mode_q == MODE_RUNNING || acc_cnt_q == count_q - CW'(1));
    wr_addr_d = vld ? (mode_q == MODE_FINAL ? '0 : acc_cnt_q[AWIDTH-1:0]) : wr_addr_q;
    ovf_d     = accept ? 1'b0 : ovf_q | (|lane_ovf);
    vld_d[0]  = state_q == ST_RUN;
    for (int i = 1; i < RD_LATENCY; i++) vld_d[i] = vld_q[i-1];
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  state_d = accept ? (count_d == '0 ? ST_DONE : ST_RUN) : ST_IDLE;
      ST_RUN:   state_d = rd_cnt_q == count_q - CW'(1) ? ST_DRAIN : ST_RUN;
      ST_DRAIN: state_d = (vld_q == '0 && !wr_q) ? ST_DONE : ST_DRAIN;
      ST_DONE:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      rd_cnt_q  <= '0;
      acc_cnt_q <= '0;
      mode_q    <= MODE_RUNNING;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      ovf_q     <= 1'b0;
      vld_q     <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_cnt_q  <= rd_cnt_d;
      acc_cnt_q <= acc_cnt_d;
      mode_q    <= mode_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      ovf_q     <= ovf_d;
      vld_q     <= vld_d;
    end

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    bram_acc_lane #(
      .IN_WIDTH (IN_WIDTH),
      .ACC_WIDTH(ACC_WIDTH)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .clr_i(accept),
      .vld_i(vld),
      .in_i (q_b0_i[lane_lsb(k, IN_WIDTH) +: IN_WIDTH]),
      .sum_o(d_b1_o[lane_lsb(k, ACC_WIDTH) +: ACC_WIDTH]),
      .ovf_o(lane_ovf[k])
    );
  end

  assign addr_b0_o  = rd_cnt_q[AWIDTH-1:0];
  assign ce_b0_o    = state_q == ST_RUN;
  assign we_b0_o    = 1'b0;
  assign d_b0_o     = '0;
  assign addr_b1_o  = wr_addr_q;
  assign ce_b1_o    = wr_q;
  assign we_b1_o    = wr_q;
  assign idle_o     = state_q == ST_IDLE;
  assign read_o     = ce_b0_o;
  assign write_o    = wr_q;
  assign done_o     = state_q == ST_DONE;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_bram_lane_accumulator.sv
// tb_bram_lane_accumulator: directed bench; DUT a uses defaults, DUT b uses ACC_WIDTH=8, RD_LATENCY=3.
module tb_bram_lane_accumulator;

  logic        clk = 1'b0, reset = 1'b1, start_a = 1'b0, start_b = 1'b0, mode = 1'b0;
  logic [8:0]  run_count = '0;
  logic [31:0] mem [0:255];
  logic [31:0] q_a = '0, q_b = '0, q_b1 = '0, q_b2 = '0;

  logic [7:0]  addr_b0_a, addr_b1_a, addr_b0_b, addr_b1_b;
  logic        ce_b0_a, we_b0_a, ce_b1_a, we_b1_a, idle_a, read_a, write_a, done_a, ovf_a;
  logic        ce_b0_b, we_b0_b, ce_b1_b, we_b1_b, idle_b, read_b, write_b, done_b, ovf_b;
  logic [31:0] d_b0_a, d_b0_b, d_b1_b;
  logic [63:0] d_b1_a;

  int n_tests = 0, n_fail = 0, cyc = 0, start_cyc = 0;
  int rd_a = 0, wr_a = 0, dn_a = 0, dn_a_cyc = 0, lw_a = 0, wr_b = 0, dn_b = 0, first_b = 0;
  logic [63:0] wa [0:255];
  logic [31:0] wb [0:255];

  bram_lane_accumulator dut_a (
    .clk(clk), .reset(reset), .start_i(start_a), .run_count_i(run_count), .mode_i(mode),
    .q_b0_i(q_a), .addr_b0_o(addr_b0_a), .ce_b0_o(ce_b0_a), .we_b0_o(we_b0_a), .d_b0_o(d_b0_a),
    .addr_b1_o(addr_b1_a), .ce_b1_o(ce_b1_a), .we_b1_o(we_b1_a), .d_b1_o(d_b1_a),
    .idle_o(idle_a), .read_o(read_a), .write_o(write_a), .done_o(done_a), .overflow_o(ovf_a)
  );

  bram_lane_accumulator #(.ACC_WIDTH(8), .RD_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .start_i(start_b), .run_count_i(run_count), .mode_i(mode),
    .q_b0_i(q_b), .addr_b0_o(addr_b0_b), .ce_b0_o(ce_b0_b), .we_b0_o(we_b0_b), .d_b0_o(d_b0_b),
    .addr_b1_o(addr_b1_b), .ce_b1_o(ce_b1_b), .we_b1_o(we_b1_b), .d_b1_o(d_b1_b),
    .idle_o(idle_b), .read_o(read_b), .write_o(write_b), .done_o(done_b), .overflow_o(ovf_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (ce_b0_a) q_a <= mem[addr_b0_a];
    if (ce_b0_b) q_b1 <= mem[addr_b0_b];
    q_b2 <= q_b1;
    q_b  <= q_b2;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ce_b0_a) begin
      check("rd_addr_a", 64'(addr_b0_a), 64'(rd_a[7:0]));
      rd_a++;
    end
    if (ce_b1_a) begin
      wa[addr_b1_a] = d_b1_a;
      wr_a++;
      lw_a = cyc;
    end
    if (done_a) begin
      dn_a++;
      dn_a_cyc = cyc;
    end
    if (ce_b1_b) begin
      if (wr_b == 0) first_b = cyc;
      wb[addr_b1_b] = d_b1_b;
      wr_b++;
    end
    if (done_b) dn_b++;
  end

  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic go(input bit b, input logic [8:0] n, input logic m);
    @(negedge clk);
    rd_a = 0; wr_a = 0; dn_a = 0; wr_b = 0; dn_b = 0; first_b = 0;
    run_count = n;
    mode = m;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit b);
    int i = 0;
    while ((b ? dn_b : dn_a) == 0 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check("done_seen", 64'((b ? dn_b : dn_a) != 0), 64'(1));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    fill(32'h0403_0201);
    repeat (3) @(negedge clk);
    check("rst_idle", 64'(idle_a), 64'(1));
    check("rst_ce_b0", 64'(ce_b0_a), 64'(0));
    check("rst_ce_b1", 64'(ce_b1_a), 64'(0));
    check("rst_done", 64'(done_a), 64'(0));
    check("rst_ovf", 64'(ovf_a), 64'(0));
    reset = 1'b0;

    go(1'b0, 9'd3, 1'b0);
    wait_done(1'b0);
    check("run_wr_cnt", 64'(wr_a), 64'(3));
    check("run_rd_cnt", 64'(rd_a), 64'(3));
    check("run_addr0", wa[0], 64'h0004_0003_0002_0001);
    check("run_addr1", wa[1], 64'h0008_0006_0004_0002);
    check("run_addr2", wa[2], 64'h000C_0009_0006_0003);
    check("run_done_cnt", 64'(dn_a), 64'(1));
    check("run_done_after_wr", 64'(dn_a_cyc > lw_a), 64'(1));
    check("run_ovf", 64'(ovf_a), 64'(0));
    check("run_idle", 64'(idle_a), 64'(1));

    wa[0] = '0;
    go(1'b0, 9'd3, 1'b1);
    wait_done(1'b0);
    check("fin_wr_cnt", 64'(wr_a), 64'(1));
    check("fin_addr0", wa[0], 64'h000C_0009_0006_0003);
    check("fin_done_cnt", 64'(dn_a), 64'(1));

    go(1'b0, 9'd0, 1'b0);
    wait_done(1'b0);
    check("zero_rd_cnt", 64'(rd_a), 64'(0));
    check("zero_wr_cnt", 64'(wr_a), 64'(0));
    check("zero_done_lat", 64'(dn_a_cyc - start_cyc), 64'(1));
    check("zero_idle", 64'(idle_a), 64'(1));

    go(1'b0, 9'd300, 1'b1);
    wait_done(1'b0);
    check("clamp_rd_cnt", 64'(rd_a), 64'(256));
    check("clamp_sum", wa[0], 64'h0400_0300_0200_0100);

    fill(32'hFFFF_FFFF);
    go(1'b1, 9'd2, 1'b1);
    wait_done(1'b1);
    check("ovf_wr_cnt", 64'(wr_b), 64'(1));
`ifdef BRAM_ACC_SAT_EN
    check("ovf_sum", 64'(wb[0]), 64'h0000_0000_FFFF_FFFF);
`else
    check("ovf_sum", 64'(wb[0]), 64'h0000_0000_FEFE_FEFE);
`endif
    check("ovf_flag", 64'(ovf_b), 64'(1));

    fill(32'h0101_0101);
    go(1'b1, 9'd4, 1'b0);
    wait_done(1'b1);
    check("lat_first_wr", 64'(first_b - start_cyc), 64'(5));
    check("lat_wr_cnt", 64'(wr_b), 64'(4));
    check("lat_addr0", 64'(wb[0]), 64'h0101_0101);
    check("lat_addr1", 64'(wb[1]), 64'h0202_0202);
    check("lat_addr2", 64'(wb[2]), 64'h0303_0303);
    check("lat_addr3", 64'(wb[3]), 64'h0404_0404);
    check("lat_ovf_cleared", 64'(ovf_b), 64'(0));

    fill(32'h0403_0201);
    go(1'b0, 9'd3, 1'b0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(1'b0);
    check("ign_wr_cnt", 64'(wr_a), 64'(3));
    check("ign_done_cnt", 64'(dn_a), 64'(1));
    check("ign_addr2", wa[2], 64'h000C_0009_0006_0003);

    go(1'b0, 9'd8, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_idle", 64'(idle_a), 64'(1));
    check("mid_rst_ce_b0", 64'(ce_b0_a), 64'(0));
    check("mid_rst_ce_b1", 64'(ce_b1_a), 64'(0));
    check("mid_rst_d_b1", d_b1_a, 64'(0));
    check("mid_rst_done", 64'(done_a), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    go(1'b0, 9'd3, 1'b0);
    wait_done(1'b0);
    check("post_rst_wr_cnt", 64'(wr_a), 64'(3));
    check("post_rst_addr0", wa[0], 64'h0004_0003_0002_0001);
    check("post_rst_addr2", wa[2], 64'h000C_0009_0006_0003);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
